// File: rtl/bsg_flow_clear_up_counter_set.sv
// Two independent counters on one clock: a clear/up counter with programmable
// wrap point, and a saturating occupancy/credit counter for flow control.
module bsg_flow_clear_up_counter_set #(
  parameter int unsigned max_val_p          = 4,
  parameter int unsigned init_val_p         = 0,
  parameter int unsigned els_p              = 4,
  parameter bit          ready_then_valid_p = 1'b0,
  parameter bit          count_free_p       = 1'b0,
  localparam int unsigned width_a = (max_val_p < 1) ? 1 : $clog2(max_val_p + 1),
  localparam int unsigned width_b = (els_p < 1) ? 1 : $clog2(els_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_a-1:0] count_o,
  input  logic               v_i,
  input  logic               ready_param_i,
  input  logic               yumi_i,
  output logic [width_b-1:0] flow_count_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [width_a-1:0] count_q, count_d;
  logic [width_b-1:0] occ_q, occ_d;
  logic               enq;
  logic               deq;

  // Clear/up counter: clear takes priority, a simultaneous up counts this event.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = up_i ? width_a'(1) : '0;
    end else if (up_i) begin
      count_d = (count_q == width_a'(max_val_p)) ? '0 : count_q + width_a'(1);
    end
  end

  // Occupancy counter: simultaneous enq/deq cancel; saturates at both ends.
  always_comb begin
    enq   = ready_then_valid_p ? v_i : (v_i & ready_param_i);
    deq   = yumi_i;
    occ_d = occ_q;
    if (enq && !deq && (occ_q != width_b'(els_p))) begin
      occ_d = occ_q + width_b'(1);
    end else if (deq && !enq && (occ_q != '0)) begin
      occ_d = occ_q - width_b'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= width_a'(init_val_p);
      occ_q   <= '0;
    end else begin
      count_q <= count_d;
      occ_q   <= occ_d;
    end
  end

  assign count_o      = count_q;
  assign flow_count_o = count_free_p ? (width_b'(els_p) - occ_q) : occ_q;
  assign full_o       = (occ_q == width_b'(els_p));
  assign empty_o      = (occ_q == '0);

endmodule

// File: tb/tb_bsg_flow_clear_up_counter_set.sv
// Scoreboard bench: three parameterisations share one stimulus stream; a
// queue of expected outputs is filled by the driver and drained by a monitor.
module tb_bsg_flow_clear_up_counter_set;

  localparam int N = 3;
  localparam int P_MAX  [N] = '{5, 2, 4};
  localparam int P_INIT [N] = '{2, 0, 0};
  localparam int P_ELS  [N] = '{4, 4, 4};
  localparam int P_RTV  [N] = '{0, 1, 0};
  localparam int P_FREE [N] = '{0, 1, 1};

  typedef struct packed {
    logic [N-1:0][7:0] cnt;
    logic [N-1:0][7:0] flow;
    logic [N-1:0]      full;
    logic [N-1:0]      empty;
  } exp_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1, clear_i = 1'b0, up_i = 1'b0;
  logic v_i = 1'b0, ready_param_i = 1'b0, yumi_i = 1'b0;

  logic [2:0] c0, c2, f0, f1, f2;
  logic [1:0] c1;
  logic       full0, full1, full2, empty0, empty1, empty2;

  exp_t q[$];
  int   m_cnt [N];
  int   m_occ [N];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bsg_flow_clear_up_counter_set #(.max_val_p(5), .init_val_p(2), .els_p(4),
    .ready_then_valid_p(1'b0), .count_free_p(1'b0)) u0 (
    .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i), .up_i(up_i), .count_o(c0),
    .v_i(v_i), .ready_param_i(ready_param_i), .yumi_i(yumi_i),
    .flow_count_o(f0), .full_o(full0), .empty_o(empty0));

  bsg_flow_clear_up_counter_set #(.max_val_p(2), .init_val_p(0), .els_p(4),
    .ready_then_valid_p(1'b1), .count_free_p(1'b1)) u1 (
    .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i), .up_i(up_i), .count_o(c1),
    .v_i(v_i), .ready_param_i(ready_param_i), .yumi_i(yumi_i),
    .flow_count_o(f1), .full_o(full1), .empty_o(empty1));

  bsg_flow_clear_up_counter_set #(.max_val_p(4), .init_val_p(0), .els_p(4),
    .ready_then_valid_p(1'b0), .count_free_p(1'b1)) u2 (
    .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i), .up_i(up_i), .count_o(c2),
    .v_i(v_i), .ready_param_i(ready_param_i), .yumi_i(yumi_i),
    .flow_count_o(f2), .full_o(full2), .empty_o(empty2));

  // Drive one cycle of stimulus and record what every instance should show after it.
  task automatic step(input logic r, input logic c, input logic u,
                      input logic v, input logic rd, input logic y);
    exp_t e;
    int   enq;
    @(negedge clk);
    reset_i = r; clear_i = c; up_i = u; v_i = v; ready_param_i = rd; yumi_i = y;
    for (int i = 0; i < N; i++) begin
      if (r) begin
        m_cnt[i] = P_INIT[i];
        m_occ[i] = 0;
      end else begin
        if (c)      m_cnt[i] = u ? 1 : 0;
        else if (u) m_cnt[i] = (m_cnt[i] + 1) % (P_MAX[i] + 1);
        enq = (P_RTV[i] != 0) ? int'(v) : int'(v & rd);
        m_occ[i] = m_occ[i] + enq - int'(y);
        if (m_occ[i] < 0)        m_occ[i] = 0;
        if (m_occ[i] > P_ELS[i]) m_occ[i] = P_ELS[i];
      end
      e.cnt[i]   = 8'(m_cnt[i]);
      e.flow[i]  = 8'((P_FREE[i] != 0) ? (P_ELS[i] - m_occ[i]) : m_occ[i]);
      e.full[i]  = (m_occ[i] == P_ELS[i]);
      e.empty[i] = (m_occ[i] == 0);
    end
    q.push_back(e);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[%0d] at %0t: actual=%0d required=%0d", name, idx, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUTs present new state; compare it against the queue head.
  initial begin
    exp_t e;
    int   ac [N];
    int   af [N];
    int   afl[N];
    int   aem[N];
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        ac[0] = int'(c0); ac[1] = int'(c1); ac[2] = int'(c2);
        af[0] = int'(f0); af[1] = int'(f1); af[2] = int'(f2);
        afl[0] = int'(full0);  afl[1] = int'(full1);  afl[2] = int'(full2);
        aem[0] = int'(empty0); aem[1] = int'(empty1); aem[2] = int'(empty2);
        for (int i = 0; i < N; i++) begin
          check("count_o", i, ac[i], int'(e.cnt[i]));
          check("flow_count_o", i, af[i], int'(e.flow[i]));
          check("full_o", i, afl[i], int'(e.full[i]));
          check("empty_o", i, aem[i], int'(e.empty[i]));
        end
      end
    end
  end

  initial begin
    int waited;
    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Clear/up sequence including wrap at max
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Valid without ready, then fill to full and push past it
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 1, 1, 0);
    // Drain to 2, simultaneous enq/deq, then drain past empty
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1);
    // Free-count view: two enqueues then one dequeue
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    // Reset in mid-operation with up and v active
    step(0, 1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    // Randomized traffic with occasional reset
    for (int k = 0; k < 500; k++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0), 1'($urandom),
           1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
    end
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: actual=%0d pending required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
